// File: rtl/cnu_row_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : cnu_row_scheduler
// Purpose  : Row sequencer that drives one CNU and the message memory through
//            every check row of each decoding iteration.
// Options  : EARLY_TERM_EN - stop as soon as a check phase has a zero syndrome
// Revision : 1.0 - initial release
// ============================================================================
module cnu_row_scheduler #(
    parameter int NUM_ROWS = 24,
    parameter int ADDR_W   = 5,
    parameter int MAX_ITER = 10,
    parameter int ITER_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic              cnu_en,
    input  logic              cnu_p_bit,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic              vnu_start,
    input  logic              vnu_done,
    output logic              busy,
    output logic              done,
    output logic              success,
    output logic [ITER_W-1:0] iter_cnt
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE    = 3'd1,
        S_DRAIN    = 3'd2,
        S_VNU_WAIT = 3'd3,
        S_FINISH   = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_ROWS - 1);
    localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   row_q, row_d;
    logic                syn_q, syn_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic                succ_q, succ_d;
    logic [ITER_W-1:0]   iter_next;

    // Two-stage row pipeline: stage 1 feeds the CNU, stage 2 writes back.
    logic                s1_v_q, s2_v_q;
    logic [ADDR_W-1:0]   s1_row_q, s2_row_q;
    logic                wr_fire;
    logic                drained;

    assign wr_fire   = s2_v_q && !stall;
    assign drained   = !s1_v_q && !s2_v_q;
    assign iter_next = (iter_q == ITER_MAX) ? iter_q : iter_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        syn_d     = syn_q;
        iter_d    = iter_q;
        succ_d    = succ_q;
        mem_rd_en = 1'b0;
        vnu_start = 1'b0;
        done      = 1'b0;

        if (wr_fire) begin
            syn_d = syn_q | cnu_p_bit;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    row_d   = '0;
                    iter_d  = '0;
                    succ_d  = 1'b0;
                    syn_d   = 1'b0;
                end
            end
            S_ISSUE: begin
                if (!stall) begin
                    mem_rd_en = 1'b1;
                    if (row_q == LAST_ROW) begin
                        row_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // The last write-back has already folded into syn_q once drained.
                if (drained) begin
                    iter_d = iter_next;
`ifdef EARLY_TERM_EN
                    if (!syn_q) begin
                        state_d = S_FINISH;
                        succ_d  = 1'b1;
                    end else
`endif
                    if (iter_next == ITER_MAX) begin
                        state_d = S_FINISH;
                        succ_d  = ~syn_q;
                    end else begin
                        vnu_start = 1'b1;
                        state_d   = S_VNU_WAIT;
                    end
                end
            end
            S_VNU_WAIT: begin
                if (vnu_done) begin
                    state_d = S_ISSUE;
                    row_d   = '0;
                    syn_d   = 1'b0;
                end
            end
            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            syn_q   <= 1'b0;
            iter_q  <= '0;
            succ_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            syn_q   <= syn_d;
            iter_q  <= iter_d;
            succ_q  <= succ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q   <= 1'b0;
            s2_v_q   <= 1'b0;
            s1_row_q <= '0;
            s2_row_q <= '0;
        end else if (!stall) begin
            s1_v_q   <= mem_rd_en;
            s1_row_q <= row_q;
            s2_v_q   <= s1_v_q;
            s2_row_q <= s1_row_q;
        end
    end

    assign mem_rd_addr = mem_rd_en ? row_q : '0;
    assign cnu_en      = s1_v_q && !stall;
    assign mem_wr_en   = wr_fire;
    assign mem_wr_addr = wr_fire ? s2_row_q : '0;
    assign busy        = (state_q != S_IDLE);
    assign success     = succ_q;
    assign iter_cnt    = iter_q;

endmodule
`default_nettype wire

// File: tb/tb_cnu_row_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnu_row_scheduler
// Purpose  : Randomised self-checking bench for cnu_row_scheduler against a
//            per-iteration syndrome model; follows EARLY_TERM_EN if defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cnu_row_scheduler;
    localparam int N  = 4;
    localparam int MI = 3;
    localparam int AW = 2;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1, start = 1'b0, stall = 1'b0, cnu_p_bit = 1'b0;
    logic auto_done = 1'b0, force_done = 1'b0;
    logic vnu_done;
    logic mem_rd_en, cnu_en, mem_wr_en, vnu_start, busy, done, success;
    logic [AW-1:0] mem_rd_addr, mem_wr_addr;
    logic [IW-1:0] iter_cnt;

    assign vnu_done = auto_done | force_done;
    always #5 clk = ~clk;

    cnu_row_scheduler #(.NUM_ROWS(N), .ADDR_W(AW), .MAX_ITER(MI), .ITER_W(IW)) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .cnu_en(cnu_en),
        .cnu_p_bit(cnu_p_bit), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
        .vnu_start(vnu_start), .vnu_done(vnu_done), .busy(busy), .done(done),
        .success(success), .iter_cnt(iter_cnt)
    );

    int tests = 0, fails = 0;
    logic [N-1:0] pat [MI];
    int  clr_gen = 0, seen_gen = 0;
    bit  auto_vnu = 1'b1;
    int  rd_q[$], wr_q[$], rd_c[$], wr_c[$], pipe_q[$];
    int  vnu_cnt = 0, done_cnt = 0, viol = 0, done_iter = 0, cyc = 0;
    bit  done_succ = 1'b0;
    bit  cnu_seen = 1'b0, next_p = 1'b0, vnu_seen = 1'b0;
    int  vnu_timer = 0;

    // Observer: records the strobe streams away from the active edge.
    always @(negedge clk) begin
        int row, idx;
        cyc++;
        if (clr_gen != seen_gen) begin
            rd_q.delete(); wr_q.delete(); rd_c.delete(); wr_c.delete(); pipe_q.delete();
            vnu_cnt = 0; done_cnt = 0; viol = 0;
            seen_gen = clr_gen;
        end
        cnu_seen = 1'b0;
        vnu_seen = 1'b0;
        if (cnu_en) begin
            row = (pipe_q.size() != 0) ? pipe_q.pop_front() : 0;
            idx = (vnu_cnt < MI) ? vnu_cnt : MI - 1;
            next_p = (row < N) ? pat[idx][row] : 1'b0;
            cnu_seen = 1'b1;
        end
        if (mem_rd_en) begin
            rd_q.push_back(int'(mem_rd_addr)); rd_c.push_back(cyc);
            pipe_q.push_back(int'(mem_rd_addr));
        end
        if (mem_wr_en) begin
            wr_q.push_back(int'(mem_wr_addr)); wr_c.push_back(cyc);
        end
        if (stall && (mem_rd_en || cnu_en || mem_wr_en)) viol++;
        if (vnu_start) begin vnu_cnt++; vnu_seen = 1'b1; end
        if (done) begin done_cnt++; done_iter = int'(iter_cnt); done_succ = success; end
    end

    // CNU and VNU stand-ins: p_bit follows the row that last passed cnu_en,
    // vnu_done comes back 3 cycles after vnu_start.
    always @(posedge clk) begin
        #1;
        if (cnu_seen) cnu_p_bit = next_p;
        auto_done = 1'b0;
        if (vnu_timer > 0) begin
            vnu_timer--;
            if (vnu_timer == 0) auto_done = 1'b1;
        end
        if (vnu_seen && auto_vnu) vnu_timer = 2;
    end

    function automatic void model(output int it, output bit sc);
        it = MI;
        sc = 1'b0;
        for (int i = 0; i < MI; i++) begin
`ifdef EARLY_TERM_EN
            if (pat[i] == '0) begin it = i + 1; sc = 1'b1; return; end
`endif
            if (i == MI - 1) sc = (pat[i] == '0);
        end
    endfunction

    task automatic do_decode(input int pct, input int stall_at, input int glitch_at);
        clr_gen++;
        @(negedge clk);
        @(posedge clk); #1;
        start = 1'b1; stall = 1'b0;
        for (int k = 1; k < 3000; k++) begin
            @(posedge clk); #1;
            start      = (k == glitch_at);
            force_done = (k == glitch_at);
            stall      = ($urandom_range(99) < pct) ||
                         (stall_at >= 0 && k >= stall_at && k < stall_at + 3);
            if (done_cnt != 0) break;
        end
        start = 1'b0; stall = 1'b0; force_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({mem_rd_en, cnu_en, mem_wr_en, vnu_start, busy, done, success} !== 7'b0) begin
            fails++;
            $display("FAIL reset_strobes: got %b required 0000000",
                     {mem_rd_en, cnu_en, mem_wr_en, vnu_start, busy, done, success});
        end
        tests++;
        if (iter_cnt !== '0 || mem_rd_addr !== '0 || mem_wr_addr !== '0) begin
            fails++;
            $display("FAIL reset_values: iter %0d rd %0d wr %0d required 0", iter_cnt, mem_rd_addr, mem_wr_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int eit; bit esc; bit bad;
        for (int i = 0; i < MI; i++) pat[i] = '0;
        model(eit, esc);
        do_decode(0, -1, -1);
        tests++;
        if (done_cnt !== 1 || done_iter !== eit || done_succ !== esc) begin
            fails++;
            $display("FAIL basic_done: done %0d iter %0d succ %0d required 1 %0d %0d", done_cnt, done_iter, done_succ, eit, esc);
        end
        tests++;
        if (vnu_cnt !== eit - 1) begin
            fails++;
            $display("FAIL basic_vnu: got %0d vnu_start required %0d", vnu_cnt, eit - 1);
        end
        bad = (rd_q.size() != eit * N) || (wr_q.size() != eit * N);
        if (!bad) foreach (rd_q[k]) begin
            if (rd_q[k] != k % N || wr_q[k] != k % N || wr_c[k] - rd_c[k] != 2) bad = 1'b1;
            if (k % N != 0 && rd_c[k] - rd_c[k-1] != 1) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL basic_pipe: %0d rd %0d wr, required %0d each, consecutive, lag 2", rd_q.size(), wr_q.size(), eit * N);
        end
        tests++;
        if (busy !== 1'b0 || success !== esc || iter_cnt !== IW'(eit)) begin
            fails++;
            $display("FAIL basic_hold: busy %0d succ %0d iter %0d required 0 %0d %0d", busy, success, iter_cnt, esc, eit);
        end
    endtask

    task automatic test_pbit();
        int eit; bit esc;
        for (int i = 0; i < MI; i++) pat[i] = 4'b0100;
        model(eit, esc);
        do_decode(0, -1, -1);
        tests++;
        if (done_cnt !== 1 || done_iter !== eit || done_succ !== esc || eit !== MI) begin
            fails++;
            $display("FAIL pbit_done: done %0d iter %0d succ %0d required 1 %0d 0", done_cnt, done_iter, done_succ, MI);
        end
        tests++;
        if (vnu_cnt !== MI - 1 || rd_q.size() !== MI * N) begin
            fails++;
            $display("FAIL pbit_count: vnu %0d reads %0d required %0d %0d", vnu_cnt, rd_q.size(), MI - 1, MI * N);
        end
    endtask

    task automatic test_stall();
        bit bad;
        for (int i = 0; i < MI; i++) pat[i] = '0;
        do_decode(0, 3, -1);
        tests++;
        if (viol !== 0) begin
            fails++;
            $display("FAIL stall_strobe: %0d strobes under stall required 0", viol);
        end
        bad = (wr_q.size() < N) || (rd_q.size() != wr_q.size());
        if (!bad) foreach (wr_q[k]) if (wr_q[k] != k % N || rd_q[k] != k % N) bad = 1'b1;
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL stall_order: %0d writes not in row order, required each row once per phase", wr_q.size());
        end
        tests++;
        if (bad || wr_c[1] - rd_c[1] !== 5 || wr_c[0] - rd_c[0] !== 5) begin
            fails++;
            $display("FAIL stall_latency: row0/row1 lag %0d/%0d required 5/5",
                     bad ? -1 : wr_c[0] - rd_c[0], bad ? -1 : wr_c[1] - rd_c[1]);
        end
    endtask

    task automatic test_ignore();
        int eit; bit esc; bit bad;
        for (int i = 0; i < MI; i++) pat[i] = (i == 0) ? 4'b0001 : 4'b0000;
        model(eit, esc);
        do_decode(0, -1, 2);
        bad = (rd_q.size() != eit * N);
        if (!bad) foreach (rd_q[k]) if (rd_q[k] != k % N || (k % N != 0 && rd_c[k] - rd_c[k-1] != 1)) bad = 1'b1;
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL ignore_seq: %0d reads, required %0d consecutive in row order", rd_q.size(), eit * N);
        end
        tests++;
        if (done_cnt !== 1 || done_iter !== eit || done_succ !== esc) begin
            fails++;
            $display("FAIL ignore_done: done %0d iter %0d succ %0d required 1 %0d %0d", done_cnt, done_iter, done_succ, eit, esc);
        end
    endtask

    task automatic test_random();
        int eit; bit esc; bit bad;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < MI; i++)
                for (int j = 0; j < N; j++) pat[i][j] = ($urandom_range(4) == 0);
            model(eit, esc);
            do_decode(int'($urandom_range(40)), -1, -1);
            tests++;
            if (done_cnt !== 1 || done_iter !== eit || done_succ !== esc || vnu_cnt !== eit - 1) begin
                fails++;
                $display("FAIL rand%0d_done: done %0d iter %0d succ %0d vnu %0d required 1 %0d %0d %0d",
                         r, done_cnt, done_iter, done_succ, vnu_cnt, eit, esc, eit - 1);
            end
            bad = (viol != 0) || (rd_q.size() != eit * N) || (wr_q.size() != eit * N);
            if (!bad) foreach (wr_q[k]) if (wr_q[k] != k % N || rd_q[k] != k % N) bad = 1'b1;
            tests++;
            if (bad) begin
                fails++;
                $display("FAIL rand%0d_rows: rd %0d wr %0d viol %0d required %0d %0d 0 in order",
                         r, rd_q.size(), wr_q.size(), viol, eit * N, eit * N);
            end
        end
    endtask

    task automatic test_rst_vnu_wait();
        int eit; bit esc; bit hit;
        auto_vnu = 1'b0;
        for (int i = 0; i < MI; i++) pat[i] = 4'b0100;
        clr_gen++;
        @(negedge clk);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (vnu_cnt != 0) begin hit = 1'b1; break; end
            @(posedge clk); #1;
        end
        tests++;
        if (!hit) begin
            fails++;
            $display("FAIL rstvnu_reach: vnu_start %0d required 1 within 200 cycles", vnu_cnt);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({mem_rd_en, cnu_en, mem_wr_en, vnu_start, busy, done, success} !== 7'b0 || iter_cnt !== '0) begin
            fails++;
            $display("FAIL rstvnu_outputs: strobes %b iter %0d required 0000000 0",
                     {mem_rd_en, cnu_en, mem_wr_en, vnu_start, busy, done, success}, iter_cnt);
        end
        repeat (10) @(posedge clk);
        #1;
        tests++;
        if (done_cnt !== 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rstvnu_nodone: done %0d busy %0d required 0 0", done_cnt, busy);
        end
        auto_vnu = 1'b1;
        for (int i = 0; i < MI; i++) pat[i] = '0;
        model(eit, esc);
        do_decode(0, -1, -1);
        tests++;
        if (done_cnt !== 1 || done_iter !== eit || done_succ !== esc || rd_q.size() !== eit * N) begin
            fails++;
            $display("FAIL rstvnu_restart: done %0d iter %0d succ %0d reads %0d required 1 %0d %0d %0d",
                     done_cnt, done_iter, done_succ, rd_q.size(), eit, esc, eit * N);
        end
    endtask

    initial begin
        for (int i = 0; i < MI; i++) pat[i] = '0;
        test_reset();
        test_basic();
        test_pbit();
        test_stall();
        test_ignore();
        test_random();
        test_rst_vnu_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
